// File: rtl/tensor_loader_pkg.sv
// Shared constants and types for the UART tensor loader.
package tensor_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INDEX,
        S_DATA,
        S_CHECK,
        S_DROP
    } state_t;

    function automatic int elems(input int channels, input int size);
        return channels * size * size;
    endfunction

endpackage

// File: rtl/tensor_loader_byte_timer.sv
// Inter-byte idle watchdog; restarts on kick, holds at zero when disabled.
module byte_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Fires on the TIMEOUT-th consecutive idle cycle.
    assign expired = enable && !kick && (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (kick || !enable || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tensor_loader.sv
// Parses framed UART bytes into a tensor buffer and tracks per-tensor
// checksum validity.
module tensor_loader
    import tensor_loader_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int IN_CHANNELS = 1,
    parameter int IN_SIZE     = 4,
    parameter int TIMEOUT     = 1_000_000,
    localparam int ELEMS      = elems(IN_CHANNELS, IN_SIZE),
    localparam int AW         = $clog2(NUM_INPUTS * ELEMS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [7:0]            wr_data,
    output logic [NUM_INPUTS-1:0] valid_mask,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CW    = $clog2(ELEMS + 2);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic [NUM_INPUTS-1:0] valid_mask_q, valid_mask_d;
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  err_q, err_d;
    logic                  acc;
    logic                  expired;

    assign rx_ready   = rst_n;
    assign acc        = rx_valid && rx_ready;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign valid_mask = valid_mask_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

    byte_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .kick    (acc),
        .enable  (state_q != S_IDLE),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        valid_mask_d = valid_mask_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_d        = 1'b0;

        if (expired) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (acc) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_INDEX;
                    end
                end
                S_INDEX: begin
                    cnt_d = '0;
                    if (32'(rx_data) < 32'(NUM_INPUTS)) begin
                        valid_mask_d[rx_data[IDX_W-1:0]] = 1'b0;
                        idx_d   = rx_data[IDX_W-1:0];
                        sum_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
                S_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(idx_q) * AW'(ELEMS) + AW'(cnt_q);
                    wr_data_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CW'(ELEMS - 1)) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rx_data == sum_q) begin
                        valid_mask_d[idx_q] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                S_DROP: begin
                    // Swallows the data bytes plus the checksum.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ELEMS)) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            valid_mask_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            valid_mask_q <= valid_mask_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_tensor_loader.sv
// Directed bench for tensor_loader: good/bad frames, drop, timeout, reset.
module tb_tensor_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] valid_mask;
    logic       busy;
    logic       err;

    int n_tests;
    int n_fail;
    int err_cnt;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  dat[16];

    tensor_loader #(
        .NUM_INPUTS  (4),
        .IN_CHANNELS (1),
        .IN_SIZE     (4),
        .TIMEOUT     (50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .valid_mask (valid_mask),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wa_q.push_back(32'(wr_addr));
                wd_q.push_back(32'(wr_data));
            end
            if (err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] idx, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(idx);
        for (int i = 0; i < 16; i++) send_byte(dat[i]);
        send_byte(cs);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        err_cnt = 0;
    endtask

    task automatic check_writes(input string tag, input int base);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'd16);
        if (wa_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check({tag, "_addr"}, wa_q[i], 32'(base + i));
                check({tag, "_data"}, wd_q[i], 32'(dat[i]));
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        err_cnt  = 0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mask", 32'(valid_mask), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_wren", 32'(wr_en), 32'h0);
        check("rst_ready", 32'(rx_ready), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_hi", 32'(rx_ready), 32'h1);

        // good frame, index 2, data 00..0F, sum 0x78
        for (int i = 0; i < 16; i++) dat[i] = 8'(i);
        clear_log();
        send_frame(8'h02, 8'h78);
        check_writes("good", 32);
        check("good_mask", 32'(valid_mask), 32'h4);
        check("good_err", 32'(err_cnt), 32'h0);
        check("good_busy", 32'(busy), 32'h0);

        // bad checksum on same index: writes happen, bit stays clear
        clear_log();
        send_frame(8'h02, 8'h77);
        check_writes("badcs", 32);
        check("badcs_err", 32'(err_cnt), 32'h1);
        check("badcs_mask", 32'(valid_mask), 32'h0);

        // out-of-range index 7: err at index, 17 bytes dropped
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h07);
        @(negedge clk);
        check("drop_err_at_idx", 32'(err_cnt), 32'h1);
        check("drop_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        repeat (3) @(negedge clk);
        check("drop_nwr", 32'(wa_q.size()), 32'h0);
        check("drop_err", 32'(err_cnt), 32'h1);
        check("drop_busy_end", 32'(busy), 32'h0);

        // index 0 after drop, data 10..1F, sum 0x178 -> 0x78
        for (int i = 0; i < 16; i++) dat[i] = 8'(16 + i);
        clear_log();
        send_frame(8'h00, 8'h78);
        check_writes("idx0", 0);
        check("idx0_mask", 32'(valid_mask), 32'h1);
        check("idx0_err", 32'(err_cnt), 32'h0);

        // leading junk, A5 inside data; sum = 120 - 3 + 0xA5 = 0x11A
        for (int i = 0; i < 16; i++) dat[i] = 8'(i);
        dat[3] = 8'hA5;
        clear_log();
        send_byte(8'h11);
        @(negedge clk);
        check("junk_busy", 32'(busy), 32'h0);
        send_frame(8'h01, 8'h1A);
        check_writes("a5data", 16);
        check("a5data_mask", 32'(valid_mask), 32'h3);
        check("a5data_err", 32'(err_cnt), 32'h0);

        // timeout after 5 data bytes on index 3
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h03);
        for (int i = 0; i < 5; i++) send_byte(8'(i));
        repeat (40) @(negedge clk);
        check("to_no_early", 32'(err_cnt), 32'h0);
        check("to_busy_wait", 32'(busy), 32'h1);
        for (int i = 0; i < 30 && err_cnt == 0; i++) @(negedge clk);
        check("to_err", 32'(err_cnt), 32'h1);
        @(negedge clk);
        check("to_busy", 32'(busy), 32'h0);
        check("to_mask", 32'(valid_mask), 32'h3);
        check("to_nwr", 32'(wa_q.size()), 32'h5);

        // reset mid-DATA, then a good frame on index 1
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(8'(i));
        rst_n = 1'b0;
        #1;
        check("mid_rst_mask", 32'(valid_mask), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_wren", 32'(wr_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send_frame(8'h01, 8'h1A);
        check_writes("post_rst", 16);
        check("post_rst_mask", 32'(valid_mask), 32'h2);
        check("post_rst_err", 32'(err_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
